// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable LSU data memory: funct3 codes,
// pipeline stage record and the store byte-mask helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef struct packed {
    logic        err;
    logic        is_load;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [31:0] word;
  } stage_t;

  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_B, F3_BU: byte_mask = 4'b0001 << lane;
      F3_H, F3_HU: byte_mask = 4'b0011 << lane;
      default:     byte_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a loaded word and sign- or zero-extends it.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = word[{lane, 3'b000} +: 8];
    sel_h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{sel_b[7]}}, sel_b};
      F3_BU:   data = {24'd0, sel_b};
      F3_H:    data = {{16{sel_h[15]}}, sel_h};
      F3_HU:   data = {16'd0, sel_h};
      F3_W:    data = word;
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// RV32 MEM-stage data memory: B/H/W loads and stores with byte-lane writes,
// misalign/range/funct3 checking and an RD_LAT-deep registered response pipe.
module data_mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LAT      = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          acc, oor, f3_ok, misal, err;
  logic [3:0]    wmask;
  logic [31:0]   wrep, ext;
  stage_t        s0;
  stage_t        pipe [1:RD_LAT];
  logic [RD_LAT:1] vld_pipe;

  assign req_ready = !rst;
  assign acc       = req_valid && req_ready;

  always_comb begin
    off   = req_addr - BASE_ADDR;
    idx   = off[AW+1:2];
    lane  = off[1:0];
    oor   = |(off >> (AW + 2));
    f3_ok = req_we ? (req_funct3 <= F3_W)
                   : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misal = ((req_funct3 == F3_H || req_funct3 == F3_HU) && lane[0]) ||
            (req_funct3 == F3_W && lane != 2'd0);
    err   = oor || !f3_ok || misal;
    wmask = (acc && req_we && !err) ? byte_mask(req_funct3, lane) : 4'b0000;
    case (req_funct3)
      F3_B:    wrep = {4{req_wdata[7:0]}};
      F3_H:    wrep = {2{req_wdata[15:0]}};
      default: wrep = req_wdata;
    endcase
    // Old word is captured here, so a same-edge store is not observed.
    s0 = '{err: err, is_load: !req_we, funct3: req_funct3, lane: lane, word: mem[idx]};
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (wmask[b]) mem[idx][b] <= wrep[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= acc;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe[1] <= s0;
    for (int i = 2; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  load_extend u_ext (
    .word   (pipe[RD_LAT].word),
    .lane   (pipe[RD_LAT].lane),
    .funct3 (pipe[RD_LAT].funct3),
    .data   (ext)
  );

  assign rsp_valid = vld_pipe[RD_LAT];
  assign rsp_err   = vld_pipe[RD_LAT] && pipe[RD_LAT].err;
  assign rsp_rdata = (vld_pipe[RD_LAT] && pipe[RD_LAT].is_load && !pipe[RD_LAT].err) ? ext : 32'd0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: two instances (RD_LAT 1 and 3) on shared stimulus,
// directed vector table plus random traffic checked against a byte-array model.
module tb_data_mem_lsu;

  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rdy1, rdy3, v1, v3, e1, e3;
  logic [31:0] d1, d3;

  always #5 clk = ~clk;

  data_mem_lsu #(.DEPTH_WORDS(DW), .RD_LAT(1), .BASE_ADDR(32'h0)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v1), .rsp_rdata(d1), .rsp_err(e1));

  data_mem_lsu #(.DEPTH_WORDS(DW), .RD_LAT(3), .BASE_ADDR(32'h0)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v3), .rsp_rdata(d3), .rsp_err(e3));

  typedef struct { int due; logic [31:0] d; logic e; } ent_t;
  typedef struct { logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd;
                   logic [31:0] exp_rd; logic exp_e; } vec_t;

  ent_t q1[$];
  ent_t q3[$];
  logic [7:0] mm [DW*4];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  // Reference: size/alignment/range rules applied to a flat byte array.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int unsigned size;
    logic legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    e  = !legal || (addr >= 32'(DW*4)) || ((addr % size) != 0);
    rd = 32'd0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < int'(size); i++) mm[addr + 32'(i)] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < int'(size); i++) v = v | (32'(mm[addr + 32'(i)]) << (8*i));
        if (size < 4 && !f3[2] && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
        rd = v;
      end
    end
  endfunction

  task automatic check_port(input string nm, inout ent_t q[$], input logic v, input logic [31:0] d,
                            input logic e, input logic was_rst);
    logic ev, ee;
    logic [31:0] ed;
    ev = 1'b0; ed = 32'd0; ee = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = 1'b1; ed = q[0].d; ee = q[0].e;
      void'(q.pop_front());
    end
    chk({nm, ".rsp_valid"}, 32'(v), 32'(ev));
    if (ev || was_rst) begin
      chk({nm, ".rsp_rdata"}, d, ed);
      chk({nm, ".rsp_err"}, 32'(e), 32'(ee));
    end
  endtask

  // One clock: model acceptance at the edge, then check both DUTs on the falling edge.
  task automatic step();
    logic [31:0] rd;
    logic e, was_rst;
    @(posedge clk);
    cyc++;
    was_rst = rst;
    if (rst) begin
      q1.delete();
      q3.delete();
    end else if (req_valid) begin
      model(req_we, req_funct3, req_addr, req_wdata, rd, e);
      q1.push_back('{cyc, rd, e});
      q3.push_back('{cyc + 2, rd, e});
    end
    @(negedge clk);
    chk("u1.req_ready", 32'(rdy1), 32'(!rst));
    chk("u3.req_ready", 32'(rdy3), 32'(!rst));
    check_port("u1", q1, v1, d1, e1, was_rst);
    check_port("u3", q3, v3, d3, e3, was_rst);
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    step();
  endtask

  task automatic idle();
    req_valid = 1'b0;
    step();
  endtask

  vec_t tv[$];

  initial begin
    tv.push_back('{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
    tv.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
    tv.push_back('{1'b1, 3'd0, 32'h13, 32'h00000080, 32'h0,        1'b0});
    tv.push_back('{1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0});
    tv.push_back('{1'b0, 3'd4, 32'h13, 32'h0,        32'h00000080, 1'b0});
    tv.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0});
    tv.push_back('{1'b0, 3'd1, 32'h12, 32'h0,        32'hFFFF80AD, 1'b0});
    tv.push_back('{1'b0, 3'd5, 32'h12, 32'h0,        32'h000080AD, 1'b0});
    tv.push_back('{1'b0, 3'd0, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0});
    tv.push_back('{1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 32'h0,        1'b0});
    tv.push_back('{1'b1, 3'd1, 32'h22, 32'h00001234, 32'h0,        1'b0});
    tv.push_back('{1'b0, 3'd2, 32'h20, 32'h0,        32'h1234F00D, 1'b0});
    tv.push_back('{1'b0, 3'd1, 32'h21, 32'h0,        32'h0,        1'b1});
    tv.push_back('{1'b0, 3'd1, 32'h22, 32'h0,        32'h00001234, 1'b0});
    tv.push_back('{1'b1, 3'd2, 32'h00, 32'h11111111, 32'h0,        1'b0});
    tv.push_back('{1'b1, 3'd2, 32'h02, 32'h00000055, 32'h0,        1'b1});
    tv.push_back('{1'b0, 3'd2, 32'h00, 32'h0,        32'h11111111, 1'b0});
    tv.push_back('{1'b0, 3'd2, 32'h100, 32'h0,       32'h0,        1'b1});
    tv.push_back('{1'b1, 3'd0, 32'h101, 32'h77,      32'h0,        1'b1});
    tv.push_back('{1'b0, 3'd3, 32'h00, 32'h0,        32'h0,        1'b1});
    tv.push_back('{1'b1, 3'd4, 32'h00, 32'h99,       32'h0,        1'b1});
    tv.push_back('{1'b1, 3'd2, 32'hFC, 32'h00007FFF, 32'h0,        1'b0});
    tv.push_back('{1'b0, 3'd1, 32'hFC, 32'h0,        32'h00007FFF, 1'b0});
    tv.push_back('{1'b0, 3'd5, 32'hFE, 32'h0,        32'h0,        1'b0});

    // Reset state
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;

    // Fill memory so no load ever sees an unwritten word.
    for (int w = 0; w < DW; w++) req(1'b1, 3'd2, 32'(w * 4), $urandom);

    for (int i = 0; i < tv.size(); i++) begin
      req(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wd);
      chk($sformatf("vec%0d.rdata", i), d1, tv[i].exp_rd);
      chk($sformatf("vec%0d.err", i), 32'(e1), 32'(tv[i].exp_e));
    end

    // Eight back-to-back loads; both latencies must stream them out in order.
    for (int i = 0; i < 8; i++) req(1'b0, 3'd2, 32'(32 + i * 4), 32'd0);
    for (int i = 0; i < 4; i++) idle();

    // Reset with loads in flight; a store accepted just before must survive.
    req(1'b1, 3'd2, 32'h40, 32'hA5A55A5A);
    req(1'b0, 3'd2, 32'h44, 32'd0);
    req(1'b0, 3'd2, 32'h48, 32'd0);
    rst = 1'b1;
    req(1'b1, 3'd2, 32'h40, 32'h0BAD0BAD);
    req(1'b1, 3'd2, 32'h40, 32'h0BAD0BAD);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) idle();
    req(1'b0, 3'd2, 32'h40, 32'd0);
    chk("post_rst.rdata", d1, 32'hA5A55A5A);

    // Random traffic with occasional reset pulses.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      rst = ($urandom_range(0, 99) < 2);
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DW*4 + 7));
      if ($urandom_range(0, 1) == 0) a = a & ~32'd3;
      req_valid = ($urandom_range(0, 99) < 85);
      req_we = ($urandom_range(0, 99) < 40);
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr = a;
      req_wdata = $urandom;
      step();
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) idle();
    chk("u1.pending", 32'(q1.size()), 32'd0);
    chk("u3.pending", 32'(q3.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
